// File: rtl/exch_frame_link.sv
// Exchange frame link: serialises market-data words into delimited byte frames
// and decodes delimited decision frames from a receive byte stream.
module exch_frame_link #(
  parameter logic [7:0]  MD_START  = 8'hF0,
  parameter logic [7:0]  MD_STOP   = 8'h0F,
  parameter logic [7:0]  DEC_START = 8'h80,
  parameter logic [7:0]  DEC_STOP  = 8'h01,
  parameter logic [15:0] TIMEOUT   = 16'd5000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        md_valid,
  output logic        md_ready,
  input  logic [7:0]  md_addr,
  input  logic [31:0] md_buyprice,
  input  logic [31:0] md_sellprice,
  input  logic [31:0] md_buyvol,
  input  logic [31:0] md_sellvol,
  output logic [7:0]  tx_byte,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_byte,
  input  logic        rx_dv,
  output logic        dec_valid,
  output logic [7:0]  dec_addr,
  output logic [7:0]  dec_buysell,
  output logic [31:0] dec_timestamp,
  output logic        frm_err,
  output logic [15:0] err_count,
  output logic [15:0] frames_sent
);

  typedef enum logic {ENC_IDLE, ENC_SEND} enc_state_t;
  typedef enum logic [2:0] {HUNT, ADDR, BS, TS0, TS1, TS2, TS3, STOP} dec_state_t;

  enc_state_t   enc_state, enc_next;
  logic [4:0]   byte_idx;
  logic [135:0] payload;
  logic [7:0]   bit_base;
  logic         tx_fire, last_byte, accept;

  assign md_ready  = (enc_state == ENC_IDLE) && !reset;
  assign tx_valid  = (enc_state == ENC_SEND);
  assign tx_fire   = tx_valid && tx_ready;
  assign last_byte = (byte_idx == 5'd18);
  assign accept    = md_valid && md_ready;
  assign bit_base  = {byte_idx - 5'd1, 3'b000};

  always_comb begin
    enc_next = enc_state;
    case (enc_state)
      ENC_IDLE: if (accept) enc_next = ENC_SEND;
      ENC_SEND: if (tx_fire && last_byte) enc_next = ENC_IDLE;
      default:  enc_next = ENC_IDLE;
    endcase
  end

  // Payload bytes 1..17 come LSB-first from one packed word; delimiters wrap it.
  always_comb begin
    tx_byte = 8'h00;
    if (enc_state == ENC_SEND) begin
      case (byte_idx)
        5'd0:    tx_byte = MD_START;
        5'd18:   tx_byte = MD_STOP;
        default: tx_byte = payload[bit_base +: 8];
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      enc_state   <= ENC_IDLE;
      byte_idx    <= 5'd0;
      payload     <= '0;
      frames_sent <= 16'd0;
    end else begin
      enc_state <= enc_next;
      if (accept) begin
        payload  <= {md_sellvol, md_buyvol, md_sellprice, md_buyprice, md_addr};
        byte_idx <= 5'd0;
      end else if (tx_fire) begin
        byte_idx <= last_byte ? 5'd0 : byte_idx + 5'd1;
        if (last_byte) frames_sent <= frames_sent + 16'd1;
      end
    end
  end

  dec_state_t  dec_state, dec_next;
  logic [15:0] idle_cnt;
  logic [7:0]  addr_sh, bs_sh;
  logic [31:0] ts_sh;
  logic        good_stop, bad_stop, timeout_hit;

  assign timeout_hit = !rx_dv && (dec_state != HUNT) && (idle_cnt == 16'(TIMEOUT - 16'd1));

  always_comb begin
    dec_next  = dec_state;
    good_stop = 1'b0;
    bad_stop  = 1'b0;
    if (rx_dv) begin
      case (dec_state)
        HUNT: if (rx_byte == DEC_START) dec_next = ADDR;
        ADDR: dec_next = BS;
        BS:   dec_next = TS0;
        TS0:  dec_next = TS1;
        TS1:  dec_next = TS2;
        TS2:  dec_next = TS3;
        TS3:  dec_next = STOP;
        STOP: begin
          dec_next  = HUNT;
          good_stop = (rx_byte == DEC_STOP) && ((bs_sh == 8'hF0) || (bs_sh == 8'h0F));
          bad_stop  = !good_stop;
        end
        default: dec_next = HUNT;
      endcase
    end else if (timeout_hit) begin
      dec_next = HUNT;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dec_state     <= HUNT;
      idle_cnt      <= 16'd0;
      addr_sh       <= 8'h00;
      bs_sh         <= 8'h00;
      ts_sh         <= 32'h0;
      dec_valid     <= 1'b0;
      frm_err       <= 1'b0;
      dec_addr      <= 8'h00;
      dec_buysell   <= 8'h00;
      dec_timestamp <= 32'h0;
      err_count     <= 16'd0;
    end else begin
      dec_state <= dec_next;
      dec_valid <= good_stop;
      frm_err   <= bad_stop || timeout_hit;
      if (rx_dv || dec_state == HUNT || timeout_hit) idle_cnt <= 16'd0;
      else idle_cnt <= idle_cnt + 16'd1;
      if (rx_dv) begin
        case (dec_state)
          ADDR:    addr_sh      <= rx_byte;
          BS:      bs_sh        <= rx_byte;
          TS0:     ts_sh[7:0]   <= rx_byte;
          TS1:     ts_sh[15:8]  <= rx_byte;
          TS2:     ts_sh[23:16] <= rx_byte;
          TS3:     ts_sh[31:24] <= rx_byte;
          default: ;
        endcase
      end
      if (good_stop) begin
        dec_addr      <= addr_sh;
        dec_buysell   <= bs_sh;
        dec_timestamp <= ts_sh;
      end
      if ((bad_stop || timeout_hit) && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
    end
  end

endmodule
